// File: rtl/adj_key_conditioner.sv
// Push-button conditioner: per key 2-flop sync, debounce filter and press/auto-repeat strobe.
// Optional `AUTO_REPEAT_EN adds hold-delay and repeat pulses; otherwise one pulse per press.

module adj_key_lane #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int RPT_CYCLES  = 5_000_000
) (
  input  logic CP50,
  input  logic CR,
  input  logic key_n,
  output logic level,
  output logic pulse
);
  localparam int DW = $clog2(DEB_CYCLES);

  logic          s1, s2;
  logic          p;
  logic [DW-1:0] dcnt;
  logic          accept, press, rls;

  // Nothing to build here: the timing parameters must each be at least 2.
  if (DEB_CYCLES < 2 || HOLD_CYCLES < 2 || RPT_CYCLES < 2) begin : g_bad_params
  end

  assign p      = ~s2;
  assign accept = (p != level) && (dcnt == DW'(DEB_CYCLES - 1));
  assign press  = accept & p;
  assign rls    = accept & ~p;

  always_ff @(posedge CP50) begin
    if (CR) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b0;
      dcnt  <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      if (p == level) begin
        dcnt <= '0;
      end else if (accept) begin
        level <= p;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int RW   = $clog2(RMAX);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_t;
  st_t           st;
  logic [RW-1:0] rcnt;

  // Release beats a repeat strobe landing on the same edge.
  always_ff @(posedge CP50) begin
    if (CR) begin
      st    <= IDLE;
      rcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (rls) begin
        st   <= IDLE;
        rcnt <= '0;
      end else begin
        case (st)
          IDLE: if (press) begin
            pulse <= 1'b1;
            rcnt  <= '0;
            st    <= DELAY;
          end
          DELAY: if (rcnt == RW'(HOLD_CYCLES - 1)) begin
            pulse <= 1'b1;
            rcnt  <= '0;
            st    <= REPEAT;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
          REPEAT: if (rcnt == RW'(RPT_CYCLES - 1)) begin
            pulse <= 1'b1;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
          default: begin
            st   <= IDLE;
            rcnt <= '0;
          end
        endcase
      end
    end
  end
`else
  typedef enum logic {IDLE, HELD} st_t;
  st_t st;

  always_ff @(posedge CP50) begin
    if (CR) begin
      st    <= IDLE;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (rls) begin
        st <= IDLE;
      end else if (st == IDLE && press) begin
        pulse <= 1'b1;
        st    <= HELD;
      end
    end
  end
`endif

endmodule

module adj_key_conditioner #(
  parameter int N_KEYS      = 2,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int RPT_CYCLES  = 5_000_000
) (
  input  logic              CP50,
  input  logic              CR,
  input  logic [N_KEYS-1:0] KeyIn,
  output logic [N_KEYS-1:0] KeyLevel,
  output logic [N_KEYS-1:0] KeyPulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    adj_key_lane #(
      .DEB_CYCLES (DEB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .RPT_CYCLES (RPT_CYCLES)
    ) u_lane (
      .CP50 (CP50),
      .CR   (CR),
      .key_n(KeyIn[i]),
      .level(KeyLevel[i]),
      .pulse(KeyPulse[i])
    );
  end

endmodule

// File: tb/tb_adj_key_conditioner.sv
// Directed bench for adj_key_conditioner: a table of {inputs, tick count, expected mid/end outputs}.
// Pulses are expected low on every tick of a record except where the record's end value says otherwise.

module tb_adj_key_conditioner;
  logic       CP50 = 1'b0;
  logic       CR   = 1'b1;
  logic [1:0] KeyIn = 2'b11;
  logic [1:0] KeyLevel, KeyPulse;

  int checks = 0;
  int errors = 0;

`ifdef AUTO_REPEAT_EN
  localparam logic RP = 1'b1;
`else
  localparam logic RP = 1'b0;
`endif

  adj_key_conditioner #(
    .N_KEYS     (2),
    .DEB_CYCLES (4),
    .HOLD_CYCLES(20),
    .RPT_CYCLES (8)
  ) dut (
    .CP50    (CP50),
    .CR      (CR),
    .KeyIn   (KeyIn),
    .KeyLevel(KeyLevel),
    .KeyPulse(KeyPulse)
  );

  always #5 CP50 = ~CP50;

  typedef struct {
    string      name;
    logic       cr;
    logic [1:0] ki;
    int         n;
    logic [1:0] lvl_mid;
    logic [1:0] lvl_end;
    logic [1:0] pls_end;
  } vec_t;

  vec_t vec[$];

  task automatic add(input string nm, input logic cr, input logic [1:0] ki, input int n,
                     input logic [1:0] lm, input logic [1:0] le, input logic [1:0] pe);
    vec_t v;
    v.name = nm; v.cr = cr; v.ki = ki; v.n = n;
    v.lvl_mid = lm; v.lvl_end = le; v.pls_end = pe;
    vec.push_back(v);
  endtask

  function automatic logic [1:0] rp(input logic [1:0] p);
    return RP ? p : 2'b00;
  endfunction

  initial begin
    vec_t       v;
    logic       bad;
    logic [1:0] bl, bp;
    int         bi;

    add("reset", 1'b1, 2'b11, 2, 2'b00, 2'b00, 2'b00);
    add("idle", 1'b0, 2'b11, 50, 2'b00, 2'b00, 2'b00);
    for (int b = 0; b < 5; b++) begin
      add("bounce_lo", 1'b0, 2'b10, 3, 2'b00, 2'b00, 2'b00);
      add("bounce_hi", 1'b0, 2'b11, 1, 2'b00, 2'b00, 2'b00);
    end
    add("press0", 1'b0, 2'b10, 6, 2'b00, 2'b01, 2'b01);
    add("hold_first", 1'b0, 2'b10, 20, 2'b01, 2'b01, rp(2'b01));
    for (int r = 0; r < 6; r++)
      add("hold_rpt", 1'b0, 2'b10, 8, 2'b01, 2'b01, rp(2'b01));
    add("hold_tail", 1'b0, 2'b10, 2, 2'b01, 2'b01, 2'b00);
    add("rel_vs_rpt", 1'b0, 2'b11, 6, 2'b01, 2'b00, 2'b00);
    add("press0_b", 1'b0, 2'b10, 6, 2'b00, 2'b01, 2'b01);
    add("in_delay", 1'b0, 2'b10, 9, 2'b01, 2'b01, 2'b00);
    add("rel_delay", 1'b0, 2'b11, 6, 2'b01, 2'b00, 2'b00);
    add("quiet", 1'b0, 2'b11, 30, 2'b00, 2'b00, 2'b00);
    add("repress", 1'b0, 2'b10, 6, 2'b00, 2'b01, 2'b01);
    add("repress_hold", 1'b0, 2'b10, 20, 2'b01, 2'b01, rp(2'b01));
    add("rel_repeat", 1'b0, 2'b11, 6, 2'b01, 2'b00, 2'b00);
    add("both", 1'b0, 2'b00, 6, 2'b00, 2'b11, 2'b11);
    add("both_hold", 1'b0, 2'b00, 20, 2'b11, 2'b11, rp(2'b11));
    add("both_rpt", 1'b0, 2'b00, 8, 2'b11, 2'b11, rp(2'b11));
    add("cr_mid", 1'b1, 2'b00, 1, 2'b00, 2'b00, 2'b00);
    add("post_cr", 1'b0, 2'b00, 6, 2'b00, 2'b11, 2'b11);
    add("post_hold", 1'b0, 2'b00, 20, 2'b11, 2'b11, rp(2'b11));
    add("post_rpt", 1'b0, 2'b00, 8, 2'b11, 2'b11, rp(2'b11));

    for (int r = 0; r < vec.size(); r++) begin
      v = vec[r];
      bad = 1'b0; bl = '0; bp = '0; bi = 0;
      for (int i = 0; i < v.n; i++) begin
        CR = v.cr;
        KeyIn = v.ki;
        @(posedge CP50);
        #1;
        if (i < v.n - 1 && !bad && (KeyLevel !== v.lvl_mid || KeyPulse !== 2'b00)) begin
          bad = 1'b1; bl = KeyLevel; bp = KeyPulse; bi = i;
        end
      end
      if (v.n > 1) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s[%0d] mid tick %0d: level=%b pulse=%b, want level=%b pulse=00",
                   v.name, r, bi, bl, bp, v.lvl_mid);
        end
      end
      checks++;
      if (KeyLevel !== v.lvl_end || KeyPulse !== v.pls_end) begin
        errors++;
        $display("FAIL %s[%0d] end: level=%b pulse=%b, want level=%b pulse=%b",
                 v.name, r, KeyLevel, KeyPulse, v.lvl_end, v.pls_end);
      end
    end

    // Strobe must drop on the very next edge after the final repeat.
    CR = 1'b0;
    KeyIn = 2'b00;
    @(posedge CP50);
    #1;
    checks++;
    if (KeyPulse !== 2'b00 || KeyLevel !== 2'b11) begin
      errors++;
      $display("FAIL strobe_width: level=%b pulse=%b, want level=11 pulse=00", KeyLevel, KeyPulse);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
